// File: rtl/rx_cnt_pkg.sv
// Shared types and constants for the UART receive frame counter.
`timescale 1ns/1ps
package rx_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned PRESCALE_MIN = 2;

endpackage

// File: rtl/rx_frame_counter_edge_div.sv
// Prescale latch and edge-within-bit counter; flags the last edge of each bit as wrap.
`timescale 1ns/1ps
import rx_cnt_pkg::*;

module rx_edge_div #(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  count,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [PRESCALE_W-1:0] ps,
  output logic                  wrap
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] ps_q, ps_d;

  assign wrap = count && (edge_cnt_q == ps_q - 1'b1);

  always_comb begin
    ps_d       = ps_q;
    edge_cnt_d = '0;
    if (start) begin
      ps_d = (prescale < PRESCALE_W'(PRESCALE_MIN)) ? PRESCALE_W'(PRESCALE_MIN) : prescale;
      // the start cycle itself is edge 0, so the first RUN cycle shows edge 1
      edge_cnt_d = PRESCALE_W'(1);
    end else if (count && !wrap) begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= '0;
      ps_q       <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      ps_q       <= ps_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign ps       = ps_q;

endmodule

// File: rtl/rx_frame_counter.sv
// Frame FSM, bit counter and bit-boundary abort for the UART receiver.
// Optional mid-bit sample strobes are enabled by RX_FRAME_CNT_SAMPLE_STB_EN.
`timescale 1ns/1ps
import rx_cnt_pkg::*;

module rx_frame_counter #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4,
  parameter int unsigned MAX_BITS   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  stop_req,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_tick,
  output logic                  frame_done,
  output logic                  aborted,
  output logic                  busy,
  output logic [2:0]            sample_stb
);

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BIT_CNT_W-1:0] fl_q, fl_d;
  logic                 pend_q, pend_d;
  logic                 bit_tick_q, bit_tick_d;
  logic                 frame_done_q, frame_done_d;
  logic                 aborted_q, aborted_d;
  logic                 start, count, wrap;
  logic [PRESCALE_W-1:0] ps;

  rx_edge_div #(
    .PRESCALE_W (PRESCALE_W)
  ) u_edge_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .count    (count),
    .prescale (prescale),
    .edge_cnt (edge_cnt),
    .ps       (ps),
    .wrap     (wrap)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    fl_d         = fl_q;
    pend_d       = pend_q;
    bit_tick_d   = 1'b0;
    frame_done_d = 1'b0;
    aborted_d    = 1'b0;
    start        = 1'b0;
    count        = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        pend_d    = 1'b0;
        if (enable) begin
          start   = 1'b1;
          state_d = RUN;
          if (frame_bits == '0)
            fl_d = BIT_CNT_W'(1);
          else if (frame_bits > BIT_CNT_W'(MAX_BITS))
            fl_d = BIT_CNT_W'(MAX_BITS);
          else
            fl_d = frame_bits;
        end
      end
      RUN: begin
        // priority: enable drop, then boundary abort, then normal counting
        if (!enable) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          pend_d    = 1'b0;
        end else if (pend_q && edge_cnt == '0) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          pend_d    = 1'b0;
          aborted_d = 1'b1;
        end else begin
          count  = 1'b1;
          pend_d = pend_q | stop_req;
          if (wrap) begin
            bit_cnt_d  = bit_cnt_q + 1'b1;
            bit_tick_d = 1'b1;
            if (bit_cnt_q + 1'b1 == fl_q) begin
              frame_done_d = 1'b1;
              state_d      = DONE;
              pend_d       = 1'b0;
            end
          end
        end
      end
      DONE: begin
        bit_cnt_d = '0;
        pend_d    = 1'b0;
        if (!enable) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        pend_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      fl_q         <= '0;
      pend_q       <= 1'b0;
      bit_tick_q   <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      fl_q         <= fl_d;
      pend_q       <= pend_d;
      bit_tick_q   <= bit_tick_d;
      frame_done_q <= frame_done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign bit_cnt    = bit_cnt_q;
  assign bit_tick   = bit_tick_q;
  assign frame_done = frame_done_q;
  assign aborted    = aborted_q;
  assign busy       = (state_q == RUN);

`ifdef RX_FRAME_CNT_SAMPLE_STB_EN
  logic [PRESCALE_W:0] half, pos;

  always_comb begin
    half       = {1'b0, ps} >> 1;
    pos        = {1'b0, edge_cnt};
    sample_stb = '0;
    if (state_q == RUN) begin
      if (half != '0 && pos == half - 1'b1) sample_stb[0] = 1'b1;
      if (pos == half)                      sample_stb[1] = 1'b1;
      if (pos == half + 1'b1)               sample_stb[2] = 1'b1;
    end
  end
`else
  logic unused_ps;
  assign unused_ps  = ^ps;
  assign sample_stb = '0;
`endif

endmodule

// File: tb/tb_rx_frame_counter.sv
// Self-checking bench for rx_frame_counter: cycle-position reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_rx_frame_counter;

  localparam int PW = 6;
  localparam int BW = 4;
  localparam int MB = 12;

  logic          clk = 1'b0;
  logic          rst, enable, stop_req;
  logic [PW-1:0] prescale;
  logic [BW-1:0] frame_bits;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          bit_tick, frame_done, aborted, busy;
  logic [2:0]    sample_stb;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  rx_frame_counter #(
    .PRESCALE_W (PW),
    .BIT_CNT_W  (BW),
    .MAX_BITS   (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .stop_req   (stop_req),
    .prescale   (prescale),
    .frame_bits (frame_bits),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .bit_tick   (bit_tick),
    .frame_done (frame_done),
    .aborted    (aborted),
    .busy       (busy),
    .sample_stb (sample_stb)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a frame is tracked as k = cycles since the enable cycle,
  // so edge = k mod ps and bit = k div ps; mode 0=idle 1=running 2=done.
  int m_mode = 0, m_k = 0, m_ps = 2, m_fl = 1;
  bit m_pend = 0, m_tick = 0, m_done = 0, m_ab = 0;

  always @(posedge clk) begin
    m_tick = 0; m_done = 0; m_ab = 0;
    if (rst) begin
      m_mode = 0; m_k = 0; m_pend = 0;
    end else begin
      case (m_mode)
        0: if (enable) begin
          m_ps   = (prescale < 2) ? 2 : int'(prescale);
          m_fl   = (frame_bits == 0) ? 1 : ((frame_bits > MB) ? MB : int'(frame_bits));
          m_k    = 1;
          m_mode = 1;
        end
        1: begin
          if (!enable) begin
            m_mode = 0; m_pend = 0;
          end else if (m_pend && (m_k % m_ps == 0)) begin
            m_mode = 0; m_pend = 0; m_ab = 1;
          end else begin
            if (stop_req) m_pend = 1;
            m_k++;
            m_tick = (m_k % m_ps == 0);
            if (m_k == m_fl * m_ps) begin
              m_done = 1; m_mode = 2; m_pend = 0;
            end
          end
        end
        default: if (!enable) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    int e_edge, e_bit, h;
    logic [2:0] e_stb;
    if (chk_en) begin
      e_edge = (m_mode == 1) ? (m_k % m_ps) : 0;
      e_bit  = (m_mode == 1) ? (m_k / m_ps) : (m_done ? m_fl : 0);
      e_stb  = 3'b000;
`ifdef RX_FRAME_CNT_SAMPLE_STB_EN
      if (m_mode == 1) begin
        h = m_ps / 2;
        if (e_edge == h - 1) e_stb[0] = 1'b1;
        if (e_edge == h)     e_stb[1] = 1'b1;
        if (e_edge == h + 1) e_stb[2] = 1'b1;
      end
`else
      h = 0;
`endif
      check("m_edge_cnt",   32'(edge_cnt),   32'(e_edge));
      check("m_bit_cnt",    32'(bit_cnt),    32'(e_bit));
      check("m_bit_tick",   32'(bit_tick),   32'(m_tick));
      check("m_frame_done", 32'(frame_done), 32'(m_done));
      check("m_aborted",    32'(aborted),    32'(m_ab));
      check("m_busy",       32'(busy),       32'(m_mode == 1));
      check("m_sample_stb", 32'(sample_stb), 32'(e_stb));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int e, input int b, input string name);
    bit found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      if (edge_cnt == PW'(e) && bit_cnt == BW'(b) && busy) found = 1;
      else step();
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic run_to_done(input int bound, output int t_done, output int bc_done, output int ticks);
    t_done = -1; bc_done = -1; ticks = 0;
    for (int c = 1; c <= bound && t_done < 0; c++) begin
      step();
      if (bit_tick) ticks++;
      if (frame_done) begin t_done = c; bc_done = int'(bit_cnt); end
    end
  endtask

  initial begin
    int t_done, bc, ticks, t_ab, any_ab;
    rst = 1; enable = 0; stop_req = 0; prescale = 8; frame_bits = 10;
    step(); step();
    chk_en = 1;
    check("reset_busy", 32'(busy), 0);
    check("reset_outs", 32'({edge_cnt, bit_cnt, bit_tick, frame_done, aborted}), 0);
    rst = 0;
    step();

    // 1: full frame
    prescale = 8; frame_bits = 10; enable = 1;
    run_to_done(120, t_done, bc, ticks);
    check("t1_done_cycle", 32'(t_done), 80);
    check("t1_ticks", 32'(ticks), 10);
    check("t1_bitcnt", 32'(bc), 10);
    check("t1_busy_in_done", 32'(busy), 0);
    step(); step();
    check("t1_done_held", 32'({busy, edge_cnt, bit_cnt, frame_done}), 0);
    enable = 0; step(); step();

    // 2: stop at edge 3 of bit 2
    prescale = 8; frame_bits = 10; enable = 1;
    wait_pos(3, 2, "t2_reach");
    stop_req = 1;
    t_ab = -1;
    for (int c = 1; c <= 20 && t_ab < 0; c++) begin
      step();
      stop_req = 0;
      if (aborted) t_ab = c;
    end
    check("t2_abort_cycle", 32'(t_ab), 6);
    check("t2_counters", 32'({edge_cnt, bit_cnt, busy}), 0);
    enable = 0; step(); step();

    // 3: enable dropped mid-frame
    prescale = 8; frame_bits = 10; enable = 1;
    wait_pos(5, 4, "t3_reach");
    enable = 0;
    step();
    check("t3_idle", 32'({busy, edge_cnt, bit_cnt, frame_done, aborted}), 0);
    step();

    // 4: minimum prescale / frame length, then clamp to MAX_BITS
    prescale = 1; frame_bits = 0; enable = 1;
    run_to_done(20, t_done, bc, ticks);
    check("t4_min_done", 32'(t_done), 2);
    check("t4_min_bitcnt", 32'(bc), 1);
    enable = 0; step();
    prescale = 1; frame_bits = 15; enable = 1;
    run_to_done(60, t_done, bc, ticks);
    check("t4_clamp_done", 32'(t_done), 24);
    check("t4_clamp_bitcnt", 32'(bc), 12);
    enable = 0; step();

    // 5: stop pending on the final wrap, then reset mid-frame
    prescale = 4; frame_bits = 3; enable = 1;
    wait_pos(1, 2, "t5_reach");
    stop_req = 1;
    t_done = -1; any_ab = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      stop_req = 0;
      if (frame_done) t_done = c;
      if (aborted) any_ab = 1;
    end
    check("t5_done_cycle", 32'(t_done), 3);
    check("t5_no_abort", 32'(any_ab), 0);
    enable = 0; step();
    prescale = 8; frame_bits = 10; enable = 1;
    repeat (13) step();
    rst = 1;
    step();
    check("t5_rst_outs", 32'({edge_cnt, bit_cnt, bit_tick, frame_done, aborted, busy, sample_stb}), 0);
    rst = 0; enable = 0; step();

`ifdef RX_FRAME_CNT_SAMPLE_STB_EN
    // 6: strobes at 7/8/9 of every bit with prescale 16
    prescale = 16; frame_bits = 3; enable = 1;
    for (int c = 1; c <= 47; c++) begin
      step();
      case (c % 16)
        7:       check("t6_stb", 32'(sample_stb), 1);
        8:       check("t6_stb", 32'(sample_stb), 2);
        9:       check("t6_stb", 32'(sample_stb), 4);
        default: check("t6_stb", 32'(sample_stb), 0);
      endcase
    end
    enable = 0; step(); step();
`endif

    // randomized traffic against the model
    for (int c = 0; c < 6000; c++) begin
      rst      = ($urandom_range(0, 399) == 0);
      enable   = ($urandom_range(0, 99) < 97);
      stop_req = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) == 0) prescale = PW'($urandom_range(0, 63));
      else                           prescale = PW'($urandom_range(0, 10));
      frame_bits = BW'($urandom_range(0, 15));
      step();
    end
    rst = 0; enable = 0; stop_req = 0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
